// File: rtl/plot_arbiter.sv
// Round-robin pixel-port arbiter with bounded burst lock and registered write output.
// Define PLOT_CLEAR_EN to add the full-screen clear sweeper (clear_start/clear_done, CLEAR state).
module plot_arbiter #(
    parameter int              N_REQ       = 2,
    parameter int              X_W         = 8,
    parameter int              Y_W         = 8,
    parameter int              C_W         = 3,
    parameter int              SCR_W       = 160,
    parameter int              SCR_H       = 120,
    parameter int              LOCK_MAX    = 16,
    parameter logic [C_W-1:0]  CLEAR_COLOR = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*X_W-1:0]   req_x,
    input  logic [N_REQ*Y_W-1:0]   req_y,
    input  logic [N_REQ*C_W-1:0]   req_color,
    output logic [N_REQ-1:0]       gnt,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [C_W-1:0]         color_draw,
    output logic                   plot,
    output logic                   busy
`ifdef PLOT_CLEAR_EN
    ,
    input  logic                   clear_start,
    output logic                   clear_done
`endif
);

    localparam int          RR_W  = $clog2(N_REQ);
    localparam int          CNT_W = $clog2(LOCK_MAX + 1);
    localparam int unsigned NR    = N_REQ;
    localparam bit CFG_OK = (N_REQ >= 2) && (N_REQ <= 8) && (LOCK_MAX >= 1) &&
                            (SCR_W >= 1) && (SCR_H >= 1) &&
                            (SCR_W <= 2**X_W) && (SCR_H <= 2**Y_W) &&
                            ($bits(CLEAR_COLOR) == C_W);

    if (!CFG_OK) begin : g_cfg_check
        $error("plot_arbiter: illegal parameter combination");
    end

    logic [RR_W-1:0]  rr_q, rr_d;
    logic             own_vld_q, own_vld_d;
    logic [RR_W-1:0]  own_q, own_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [C_W-1:0]   color_q, color_d;
    logic             plot_q, plot_d;
    logic             sel_vld;
    logic [RR_W-1:0]  sel;
    logic             arb_en;
    logic             clearing;

`ifdef PLOT_CLEAR_EN
    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;
    logic           clr_last_q, clr_last_d;
    logic           clear_done_q, clear_done_d;

    assign clearing   = (state_q == ST_CLEAR);
    assign clear_done = clear_done_q;
`else
    assign clearing = 1'b0;
`endif

    assign arb_en = !clearing;

    // Locked owner wins while under budget; otherwise first requester after rr, wrapping.
    always_comb begin
        sel_vld = 1'b0;
        sel     = '0;
        if (own_vld_q && req[own_q] && lock[own_q] && (cnt_q < CNT_W'(LOCK_MAX))) begin
            sel_vld = 1'b1;
            sel     = own_q;
        end else begin
            for (int unsigned k = 1; k <= NR; k++) begin
                if (!sel_vld && req[(32'(rr_q) + k) % NR]) begin
                    sel_vld = 1'b1;
                    sel     = RR_W'((32'(rr_q) + k) % NR);
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (reset_n && arb_en && sel_vld) begin
            gnt[sel] = 1'b1;
        end
    end

    always_comb begin
        rr_d      = rr_q;
        own_vld_d = own_vld_q;
        own_d     = own_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        color_d   = color_q;
        plot_d    = 1'b0;
`ifdef PLOT_CLEAR_EN
        state_d      = state_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        clr_last_d   = clr_last_q;
        clear_done_d = 1'b0;
`endif
        if (arb_en) begin
            if (sel_vld) begin
                rr_d    = sel;
                plot_d  = 1'b1;
                x_d     = req_x[int'(sel)*X_W +: X_W];
                y_d     = req_y[int'(sel)*Y_W +: Y_W];
                color_d = req_color[int'(sel)*C_W +: C_W];
                if (lock[sel]) begin
                    own_vld_d = 1'b1;
                    if (own_vld_q && (own_q == sel) && (cnt_q < CNT_W'(LOCK_MAX))) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        own_d = sel;
                        cnt_d = CNT_W'(1);
                    end
                end else begin
                    own_vld_d = 1'b0;
                    cnt_d     = '0;
                end
            end else begin
                own_vld_d = 1'b0;
                cnt_d     = '0;
            end
`ifdef PLOT_CLEAR_EN
            if (clear_start) begin
                state_d    = ST_CLEAR;
                cx_d       = '0;
                cy_d       = '0;
                clr_last_d = 1'b0;
            end
`endif
        end
`ifdef PLOT_CLEAR_EN
        // Sweep holds one extra CLEAR cycle after the last pixel so done and ARB coincide.
        else if (clr_last_q) begin
            state_d      = ST_ARB;
            clear_done_d = 1'b1;
            own_vld_d    = 1'b0;
            cnt_d        = '0;
        end else begin
            plot_d  = 1'b1;
            x_d     = cx_q;
            y_d     = cy_q;
            color_d = CLEAR_COLOR;
            if (cx_q == X_W'(SCR_W - 1)) begin
                cx_d = '0;
                if (cy_q == Y_W'(SCR_H - 1)) begin
                    clr_last_d = 1'b1;
                end else begin
                    cy_d = cy_q + Y_W'(1);
                end
            end else begin
                cx_d = cx_q + X_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q      <= RR_W'(N_REQ - 1);
            own_vld_q <= 1'b0;
            own_q     <= '0;
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            color_q   <= '0;
            plot_q    <= 1'b0;
`ifdef PLOT_CLEAR_EN
            state_q      <= ST_ARB;
            cx_q         <= '0;
            cy_q         <= '0;
            clr_last_q   <= 1'b0;
            clear_done_q <= 1'b0;
`endif
        end else begin
            rr_q      <= rr_d;
            own_vld_q <= own_vld_d;
            own_q     <= own_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            color_q   <= color_d;
            plot_q    <= plot_d;
`ifdef PLOT_CLEAR_EN
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            clr_last_q   <= clr_last_d;
            clear_done_q <= clear_done_d;
`endif
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign color_draw = color_q;
    assign plot       = plot_q;
    assign busy       = reset_n & ((|req) | plot_q | clearing);

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter: grant order, lock bursts, reset, and (with PLOT_CLEAR_EN) the clear sweep.
module tb_plot_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req, lock;
    logic [15:0] req_x, req_y;
    logic [5:0]  req_color;
    logic [1:0]  gnt;
    logic [7:0]  x, y;
    logic [2:0]  color_draw;
    logic        plot, busy;
`ifdef PLOT_CLEAR_EN
    logic        clear_start, clear_done;
`endif

    logic [7:0] rx [2];
    logic [7:0] ry [2];
    logic [2:0] rc [2];

    typedef struct packed {
        logic [7:0] px;
        logic [7:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   exp_clear = 1'b0;
    bit   exp_done  = 1'b0;
    bit   clr_push  = 1'b0;
    pix_t clr_px;

    assign req_x     = {rx[1], rx[0]};
    assign req_y     = {ry[1], ry[0]};
    assign req_color = {rc[1], rc[0]};

    plot_arbiter #(
        .N_REQ    (2),
        .X_W      (8),
        .Y_W      (8),
        .C_W      (3),
        .SCR_W    (4),
        .SCR_H    (2),
        .LOCK_MAX (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .lock       (lock),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_color  (req_color),
        .gnt        (gnt),
        .x          (x),
        .y          (y),
        .color_draw (color_draw),
        .plot       (plot),
        .busy       (busy)
`ifdef PLOT_CLEAR_EN
        ,
        .clear_start(clear_start),
        .clear_done (clear_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks one cycle at the negedge, then records the pixel the expected grant should produce.
    task automatic tick(input logic [1:0] eg);
        pix_t e;
        bit   have;
        @(negedge clk);
        have = (sb.size() > 0);
        e    = '0;
        if (have) e = sb.pop_front();
        chk("plot", 32'(plot), 32'(have));
        if (have) begin
            chk("x", 32'(x), 32'(e.px));
            chk("y", 32'(y), 32'(e.py));
            chk("color_draw", 32'(color_draw), 32'(e.pc));
        end
        chk("gnt", 32'(gnt), 32'(eg));
        chk("busy", 32'(busy), 32'((|req) | have | exp_clear));
`ifdef PLOT_CLEAR_EN
        chk("clear_done", 32'(clear_done), 32'(exp_done));
`endif
        if (eg == 2'b01) sb.push_back({rx[0], ry[0], rc[0]});
        else if (eg == 2'b10) sb.push_back({rx[1], ry[1], rc[1]});
        if (clr_push) sb.push_back(clr_px);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 2'b01;
        lock    = 2'b00;
        rx[0] = 8'd5;  ry[0] = 8'd7;  rc[0] = 3'd5;
        rx[1] = 8'd30; ry[1] = 8'd40; rc[1] = 3'd6;
`ifdef PLOT_CLEAR_EN
        clear_start = 1'b0;
`endif
        #3;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_xyc", 32'({x, y, color_draw}), 32'd0);
        req = 2'b00;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // single requester
        req = 2'b01; tick(2'b01);
        req = 2'b00; tick(2'b00);

        // rr=0 now: wrap-around order starts at requester 1
        rx[0] = 8'd10; ry[0] = 8'd20; rc[0] = 3'd1;
        req = 2'b11;
        tick(2'b10); tick(2'b01); tick(2'b10); tick(2'b01);
        req = 2'b10; tick(2'b10);
        req = 2'b11;
        tick(2'b01); tick(2'b10); tick(2'b01); tick(2'b10);

        // lock burst bounded by LOCK_MAX
        lock = 2'b01;
        for (int i = 0; i < 16; i++) tick(2'b01);
        tick(2'b10);
        tick(2'b01);
        req = 2'b00; lock = 2'b00; tick(2'b00);

        // lock released by dropping lock
        req = 2'b11; lock = 2'b01;
        tick(2'b10); tick(2'b01); tick(2'b01); tick(2'b01);
        lock = 2'b00; tick(2'b10);
        req = 2'b00; tick(2'b00);

        // mid-stream reset
        req = 2'b11; tick(2'b01);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_plot", 32'(plot), 32'd0);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_xyc", 32'({x, y, color_draw}), 32'd0);
        sb.delete();
        req = 2'b00;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(2'b00);
        req = 2'b11; tick(2'b01);
        req = 2'b00; tick(2'b00);

`ifdef PLOT_CLEAR_EN
        // clear sweep; grant in the start cycle completes, requests during sweep are held off
        req = 2'b01; clear_start = 1'b1;
        tick(2'b01);
        exp_clear = 1'b1;
        clr_push  = 1'b1;
        for (int cy = 0; cy < 2; cy++) begin
            for (int cx = 0; cx < 4; cx++) begin
                clear_start = (cy == 0 && cx == 3);
                clr_px = {8'(cx), 8'(cy), 3'd0};
                tick(2'b00);
            end
        end
        clear_start = 1'b0;
        clr_push    = 1'b0;
        tick(2'b00);
        exp_clear = 1'b0;
        exp_done  = 1'b1;
        tick(2'b01);
        exp_done = 1'b0;
        req = 2'b00; tick(2'b00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
